// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the RISC-V core pipeline
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic            v;
    logic            reg_write;
    logic [4:0]      rd_idx;
    wb_sel_e         wb_sel;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] pc_plus4;
    logic [2:0]      funct3;
    logic [1:0]      off;
  } mem_wb_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - extracts and extends a load lane from an aligned word, flagging bad formats
module load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  output logic [XLEN-1:0] data,
  output logic            err
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (off)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = off[1] ? rdata[31:16] : rdata[15:0];

    data = '0;
    err  = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_lane[7]}}, byte_lane};
      F3_LBU: data = {24'h0, byte_lane};
      F3_LH: begin
        data = {{16{half_lane[15]}}, half_lane};
        err  = off[0];
      end
      F3_LHU: begin
        data = {16'h0, half_lane};
        err  = off[0];
      end
      F3_LW: begin
        data = rdata;
        err  = (off != 2'd0);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB latch, result select, register-file write port and retire counter
module writeback_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  m_valid,
  input  logic                  m_reg_write,
  input  logic [4:0]            m_rd_idx,
  input  logic [1:0]            m_wb_sel,
  input  logic [DATA_WIDTH-1:0] m_alu_result,
  input  logic [DATA_WIDTH-1:0] m_mem_rdata,
  input  logic [DATA_WIDTH-1:0] m_pc_plus4,
  input  logic [2:0]            m_funct3,
  input  logic                  flush,
  input  logic                  hold,
  output logic                  wr_en,
  output logic [4:0]            wr_idx,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  load_err,
  output logic [63:0]           instret
);
  import riscv_pkg::*;

  mem_wb_t         latch_q;
  mem_wb_t         latch_d;
  logic [XLEN-1:0] load_data;
  logic            align_err;
  logic            err;

  // flush wins over hold: a held instruction can still be killed in place
  always_comb begin
    latch_d = latch_q;
    if (!hold) begin
      latch_d.v         = m_valid & ~flush;
      latch_d.reg_write = m_reg_write;
      latch_d.rd_idx    = m_rd_idx;
      latch_d.wb_sel    = wb_sel_e'(m_wb_sel);
      latch_d.result    = m_alu_result;
      latch_d.rdata     = m_mem_rdata;
      latch_d.pc_plus4  = m_pc_plus4;
      latch_d.funct3    = m_funct3;
      latch_d.off       = m_alu_result[1:0];
    end else if (flush) begin
      latch_d.v = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      latch_q <= '0;
      instret <= '0;
    end else begin
      latch_q <= latch_d;
      if (latch_q.v && !hold) begin
        instret <= instret + 64'd1;
      end
    end
  end

  load_align u_load_align (
    .rdata  (latch_q.rdata),
    .funct3 (latch_q.funct3),
    .off    (latch_q.off),
    .data   (load_data),
    .err    (align_err)
  );

  assign err = (latch_q.wb_sel == WB_MEM) & align_err;

  // gating with hold keeps load_err a single pulse on the retiring cycle
  always_comb begin
    wr_en    = latch_q.v & latch_q.reg_write & (latch_q.rd_idx != 5'd0) & ~hold & ~err;
    load_err = latch_q.v & err & ~hold;
    wr_idx   = latch_q.rd_idx;
    case (latch_q.wb_sel)
      WB_MEM:  wr_data = load_data;
      WB_PC4:  wr_data = latch_q.pc_plus4;
      default: wr_data = latch_q.result;
    endcase
  end

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed self-checking bench for writeback_stage
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m_valid;
  logic        m_reg_write;
  logic [4:0]  m_rd_idx;
  logic [1:0]  m_wb_sel;
  logic [31:0] m_alu_result;
  logic [31:0] m_mem_rdata;
  logic [31:0] m_pc_plus4;
  logic [2:0]  m_funct3;
  logic        flush;
  logic        hold;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
  logic        load_err;
  logic [63:0] instret;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [63:0] exp_instret = 64'd0;

  writeback_stage #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .m_valid      (m_valid),
    .m_reg_write  (m_reg_write),
    .m_rd_idx     (m_rd_idx),
    .m_wb_sel     (m_wb_sel),
    .m_alu_result (m_alu_result),
    .m_mem_rdata  (m_mem_rdata),
    .m_pc_plus4   (m_pc_plus4),
    .m_funct3     (m_funct3),
    .flush        (flush),
    .hold         (hold),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_data      (wr_data),
    .load_err     (load_err),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc4,
                       input logic [2:0] f3);
    m_valid = v; m_reg_write = rw; m_rd_idx = rd; m_wb_sel = sel;
    m_alu_result = alu; m_mem_rdata = rdata; m_pc_plus4 = pc4; m_funct3 = f3;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 3'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0; hold = 1'b0;
    drive(1'b1, 1'b1, 5'd9, 2'd0, 32'h5555AAAA, 32'h0, 32'h0, 3'd0);
    step(); step();
    tests_run++;
    if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    tests_run++;
    if (wr_idx !== 5'd0) begin tests_failed++; $display("FAIL reset_wr_idx got %0d want 0", wr_idx); end
    tests_run++;
    if (wr_data !== 32'h0) begin tests_failed++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
    tests_run++;
    if (load_err !== 1'b0) begin tests_failed++; $display("FAIL reset_load_err got %b want 0", load_err); end
    tests_run++;
    if (instret !== 64'd0) begin tests_failed++; $display("FAIL reset_instret got %0d want 0", instret); end
    idle();
    resetn = 1'b1;
    step();
    exp_instret = 64'd0;
  endtask

  task automatic test_alu_write();
    drive(1'b1, 1'b1, 5'd5, 2'd0, 32'hAAAAAAAA, 32'h0, 32'h0, 3'd0);
    step();
    tests_run++;
    if (wr_en !== 1'b1 || wr_idx !== 5'd5 || wr_data !== 32'hAAAAAAAA)
      begin tests_failed++; $display("FAIL alu_write got en=%b idx=%0d data=%h want 1/5/aaaaaaaa", wr_en, wr_idx, wr_data); end
    tests_run++;
    if (instret !== exp_instret) begin tests_failed++; $display("FAIL alu_instret_early got %0d want %0d", instret, exp_instret); end
    // reserved select 3 behaves as ALU
    drive(1'b1, 1'b1, 5'd6, 2'd3, 32'h13579BDF, 32'hFFFFFFFF, 32'h0, 3'd0);
    step();
    exp_instret++;
    tests_run++;
    if (instret !== exp_instret) begin tests_failed++; $display("FAIL alu_instret got %0d want %0d", instret, exp_instret); end
    tests_run++;
    if (wr_en !== 1'b1 || wr_idx !== 5'd6 || wr_data !== 32'h13579BDF)
      begin tests_failed++; $display("FAIL sel3_as_alu got en=%b idx=%0d data=%h want 1/6/13579bdf", wr_en, wr_idx, wr_data); end
    drive(1'b1, 1'b1, 5'd1, 2'd2, 32'h0000FFF3, 32'h0, 32'h00001004, 3'd0);
    step();
    exp_instret++;
    tests_run++;
    if (wr_en !== 1'b1 || wr_idx !== 5'd1 || wr_data !== 32'h00001004)
      begin tests_failed++; $display("FAIL pc4_write got en=%b idx=%0d data=%h want 1/1/00001004", wr_en, wr_idx, wr_data); end
    idle();
    step();
    exp_instret++;
    tests_run++;
    if (wr_en !== 1'b0 || instret !== exp_instret)
      begin tests_failed++; $display("FAIL alu_drain got en=%b instret=%0d want 0/%0d", wr_en, instret, exp_instret); end
  endtask

  task automatic test_back_to_back_loads();
    logic [2:0]  f3_tab  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  off_tab [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] exp_tab [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 5'd7 + 5'(i), 2'd1, {30'h400, off_tab[i]}, 32'h80FF7F01, 32'h0, f3_tab[i]);
      step();
      if (i > 0) exp_instret++;
      tests_run++;
      if (wr_en !== 1'b1 || load_err !== 1'b0 || wr_idx !== 5'd7 + 5'(i) || wr_data !== exp_tab[i])
        begin tests_failed++; $display("FAIL load_ext[%0d] got en=%b err=%b idx=%0d data=%h want 1/0/%0d/%h", i, wr_en, load_err, wr_idx, wr_data, 7 + i, exp_tab[i]); end
      tests_run++;
      if (instret !== exp_instret) begin tests_failed++; $display("FAIL load_instret[%0d] got %0d want %0d", i, instret, exp_instret); end
    end
    idle();
    step();
    exp_instret++;
    tests_run++;
    if (instret !== exp_instret) begin tests_failed++; $display("FAIL load_drain_instret got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_load_errors();
    logic [2:0] f3_tab  [3] = '{3'b010, 3'b001, 3'b011};
    logic [1:0] off_tab [3] = '{2'd2, 2'd1, 2'd0};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'd20, 2'd1, {30'h10, off_tab[i]}, 32'h80FF7F01, 32'h0, f3_tab[i]);
      step();
      tests_run++;
      if (load_err !== 1'b1 || wr_en !== 1'b0)
        begin tests_failed++; $display("FAIL load_err[%0d] got err=%b en=%b want 1/0", i, load_err, wr_en); end
      idle();
      step();
      exp_instret++;
      tests_run++;
      if (load_err !== 1'b0 || instret !== exp_instret)
        begin tests_failed++; $display("FAIL load_err_pulse[%0d] got err=%b instret=%0d want 0/%0d", i, load_err, instret, exp_instret); end
    end
  endtask

  task automatic test_x0_flush();
    drive(1'b1, 1'b1, 5'd0, 2'd0, 32'hCAFEF00D, 32'h0, 32'h0, 3'd0);
    step();
    tests_run++;
    if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL x0_wr_en got %b want 0", wr_en); end
    idle();
    step();
    exp_instret++;
    tests_run++;
    if (instret !== exp_instret) begin tests_failed++; $display("FAIL x0_instret got %0d want %0d", instret, exp_instret); end
    drive(1'b1, 1'b1, 5'd3, 2'd0, 32'h01020304, 32'h0, 32'h0, 3'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    tests_run++;
    if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL flush_wr_en got %b want 0", wr_en); end
    step();
    tests_run++;
    if (instret !== exp_instret) begin tests_failed++; $display("FAIL flush_instret got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b1, 5'd10, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0, 3'd0);
    step();
    hold = 1'b1;
    idle();
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (wr_en !== 1'b0 || instret !== exp_instret)
        begin tests_failed++; $display("FAIL hold_cycle[%0d] got en=%b instret=%0d want 0/%0d", k, wr_en, instret, exp_instret); end
      step();
    end
    hold = 1'b0;
    #1;
    tests_run++;
    if (wr_en !== 1'b1 || wr_idx !== 5'd10 || wr_data !== 32'hDEADBEEF)
      begin tests_failed++; $display("FAIL hold_release got en=%b idx=%0d data=%h want 1/10/deadbeef", wr_en, wr_idx, wr_data); end
    step();
    exp_instret++;
    tests_run++;
    if (wr_en !== 1'b0 || instret !== exp_instret)
      begin tests_failed++; $display("FAIL hold_once got en=%b instret=%0d want 0/%0d", wr_en, instret, exp_instret); end
  endtask

  task automatic test_reset_mid_hold();
    drive(1'b1, 1'b1, 5'd12, 2'd0, 32'h12345678, 32'h0, 32'h0, 3'd0);
    step();
    hold = 1'b1;
    resetn = 1'b0;
    idle();
    step();
    tests_run++;
    if (wr_en !== 1'b0 || wr_idx !== 5'd0 || wr_data !== 32'h0 || load_err !== 1'b0 || instret !== 64'd0)
      begin tests_failed++; $display("FAIL reset_mid got en=%b idx=%0d data=%h err=%b instret=%0d want all 0", wr_en, wr_idx, wr_data, load_err, instret); end
    hold = 1'b0;
    resetn = 1'b1;
    #1;
    tests_run++;
    if (wr_en !== 1'b0) begin tests_failed++; $display("FAIL reset_mid_release got en=%b want 0", wr_en); end
    step();
    tests_run++;
    if (instret !== 64'd0) begin tests_failed++; $display("FAIL reset_mid_instret got %0d want 0", instret); end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_back_to_back_loads();
    test_load_errors();
    test_x0_flush();
    test_hold();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

MEM/WB pipeline register and write-back unit of the 5-stage RISC-V core; the producer side of the register-file write port. It latches the retiring instruction from MEM, selects and aligns the result (ALU, load data, PC+4), drives `wr_en`/`wr_idx`/`wr_data` into `register_file`, and counts retired instructions. It also flags misaligned or illegal load formats instead of writing them.

## Interface
- `DATA_WIDTH`, 32: datapath width. Only 32 is supported.
- `clk`  input  1: clock; all state updates on rising edge.
- `resetn`  input  1: reset, synchronous and active-low.
- `m_valid`  input  1: MEM stage holds a valid instruction this cycle.
- `m_reg_write`  input  1: instruction writes `rd`.
- `m_rd_idx`  input  5: destination register.
- `m_wb_sel`  input  2: result source: ALU=0, MEM=1, PC4=2; 3 is reserved and treated as ALU.
- `m_alu_result`  input  32: ALU result; bits [1:0] are the load byte offset.
- `m_mem_rdata`  input  32: raw aligned word from data memory.
- `m_pc_plus4`  input  32: link value.
- `m_funct3`  input  3: load size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- `flush`  input  1: kill the instruction being captured this edge.
- `hold`  input  1: debug halt; freeze the latch and suppress the write.
- `wr_en`  output  1: register-file write enable.
- `wr_idx`  output  5: register-file write index.
- `wr_data`  output  32: register-file write data.
- `load_err`  output  1: single-cycle pulse for a misaligned or illegal-format load.
- `instret`  output  64: retired-instruction counter.

## Operation
- Latch: `v`, `reg_write`, `rd_idx`, `wb_sel`, `result`, `funct3`, and offset.
  - Each edge with `hold`=0, the latch captures the `m_*` inputs.
  - `v` is loaded with `m_valid & ~flush`; `flush` beats `hold` and clears `v`.
  - With `hold`=1 and `flush`=0, all latch fields keep their values.
- `wr_data` is selected from the latch:
  - ALU: `result`.
  - PC4: the latched `pc_plus4`.
  - MEM: the aligned load value, with lane = offset.
- Load alignment:
  - LB/LBU: byte `rdata[8*off+7:8*off]`, sign- or zero-extended.
  - LH/LHU: off ∈ {0,2}; halfword `rdata[8*off+15:8*off]`, extended.
  - LW: off = 0 only.
- Error case: a MEM-sourced instruction is in error when its offset is misaligned or its funct3 is 011/110/111. In that case:
  - `load_err` = 1.
  - `wr_en` = 0.
  - The instruction still retires.
- Write rules:
  - `wr_en = v & reg_write & (rd_idx≠0) & ~hold & ~err`.
  - `wr_idx = rd_idx` always; `wr_data` is valid whenever `wr_en` = 1.
  - x0 is never written.
- `instret` increments by 1 when `v & ~hold`, including non-writing instructions and `err` instructions.
  - 64-bit wrap from all-ones to 0 with no flag.
- Hold semantics: a held instruction writes and retires exactly once, in the first cycle after `hold` falls.

## Timing
- Reset (edge with `resetn`=0):
  - `v`=0, `wr_en`=0, `wr_idx`=0, `wr_data`=0, `load_err`=0, `instret`=0.
  - All latch fields are cleared.
  - Reset beats `flush` and `hold`.
- Latency:
  - An instruction in MEM during cycle N appears on `wr_*` in cycle N+1.
  - `register_file` stores it at the end of N+1.
  - A same-cycle read in N+1 is covered by the register file's internal bypass.
- `wr_*`, `load_err`: combinational from the latch and `hold` only, with no path from `m_*`.
- `instret` updates on the same edge that ends the retiring cycle.
- Back-to-back valid instructions give one write per cycle with no bubbles.
- `hold` asserted for K cycles: `wr_en`=0 for those K cycles, then one write; `instret` advances by exactly 1.
- Reset asserted mid-hold discards the held instruction: no write, no count.

## Structure
- Shared `riscv_pkg`:
  - `wb_sel_e` enum (WB_ALU, WB_MEM, WB_PC4).
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - `mem_wb_t` packed struct for the latch.
- Sub-module `load_align`: combinational (rdata, funct3, off) → (data, err). It is reused by a later MMIO path.
- Remaining content: the latch, write qualification and the `instret` counter (about 150–250 lines total).

## Test plan
- ALU write: `m_valid`=1, reg_write=1, rd=5, ALU=0xAAAAAAAA.
  - Next cycle: `wr_en`=1, `wr_idx`=5, `wr_data`=0xAAAAAAAA.
  - One cycle later: register_file x5 reads 0xAAAAAAAA and `instret`=1.
- Load extension, rdata=0x80FF7F01:
  - LB off=3 → 0xFFFFFF80; LBU off=3 → 0x00000080.
  - LH off=2 → 0xFFFF80FF; LHU off=0 → 0x00007F01; LW off=0 → 0x80FF7F01.
- Errors: LW off=2 or LH off=1 → `load_err` pulse, `wr_en`=0, `instret` still increments; funct3=011 → same response.
- x0 and flush:
  - rd=0 with reg_write=1 → `wr_en`=0, `instret` +1.
  - `flush`=1 on capture → `wr_en`=0, `instret` unchanged.
- Hold: hold=1 for 3 cycles over a valid rd=10 write of 0xDEADBEEF.
  - `wr_en`=0 throughout the hold.
  - A single write appears on release; `instret` +1 total.
- Reset mid-stream: assert `resetn`=0 while a valid write is latched → next cycle all outputs are 0, `instret`=0, and no write occurs.
